// File: rtl/omsp_spm_query_if.sv
// Bundles the omsp_spm_query signals: the execution-unit request/response
// handshake and the SPM-control read port. The slave modport is the view
// of omsp_spm_query itself. The master modport is the view of its
// surroundings (execution unit plus SPM control).
// Optional key stream signals are present only when SPM_QUERY_KEY_STREAM_EN
// is defined.
interface omsp_spm_query_if
`ifdef SPM_QUERY_KEY_STREAM_EN
  #(parameter int unsigned KEY_WORDS = 8)
`endif
;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_select;
  logic [15:0] spm_select;
  logic [2:0]  data_request;
  logic        spm_select_valid;
  logic [15:0] requested_data;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;
  logic [15:0] resp_pub_start;
  logic [15:0] resp_pub_end;
  logic [15:0] resp_sec_start;
  logic [15:0] resp_sec_end;
  logic [15:0] resp_id;
`ifdef SPM_QUERY_KEY_STREAM_EN
  // bit 0 is the MSB of key word 0
  logic [0:16*KEY_WORDS-1] key_out;
  logic [15:0]             key_word;
  logic                    key_valid;
  logic                    key_ready;
`endif

  modport slave (
    input  req_valid, req_select, spm_select_valid, requested_data, resp_ready,
`ifdef SPM_QUERY_KEY_STREAM_EN
    input  key_out, key_ready,
    output key_word, key_valid,
`endif
    output req_ready, spm_select, data_request, resp_valid, resp_err,
           resp_pub_start, resp_pub_end, resp_sec_start, resp_sec_end, resp_id
  );

  modport master (
    output req_valid, req_select, spm_select_valid, requested_data, resp_ready,
`ifdef SPM_QUERY_KEY_STREAM_EN
    output key_out, key_ready,
    input  key_word, key_valid,
`endif
    input  req_ready, spm_select, data_request, resp_valid, resp_err,
           resp_pub_start, resp_pub_end, resp_sec_start, resp_sec_end, resp_id
  );
endinterface

// File: rtl/omsp_spm_query.sv
// Requester side of the SPM array read interface. On a request it latches
// the SPM select address. It checks for a match, walks the layout fields one
// per cycle, and holds a single response until that response is accepted.
// Optional feature macro: SPM_QUERY_KEY_STREAM_EN. When it is defined, the
// 128-bit key of a matched SPM is streamed as 16-bit words before the
// response is presented.
module omsp_spm_query #(
  parameter int unsigned NB_FIELDS = 5
`ifdef SPM_QUERY_KEY_STREAM_EN
  , parameter int unsigned KEY_WORDS = 8
`endif
) (
  input logic             mclk,
  input logic             puc_rst,
  omsp_spm_query_if.slave bus
);

  localparam logic [2:0] LAST_FIELD = 3'(NB_FIELDS);

`ifdef SPM_QUERY_KEY_STREAM_EN
  localparam int unsigned WW = $clog2(KEY_WORDS);
  localparam logic [WW-1:0] LAST_WORD = WW'(KEY_WORDS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FETCH,
    S_RESP
`ifdef SPM_QUERY_KEY_STREAM_EN
    , S_KEY
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sel_q;
  logic [2:0]  cnt_q;
  logic [15:0] fields_q [1:NB_FIELDS];
  logic        err_q;
  logic        drop_q;
`ifdef SPM_QUERY_KEY_STREAM_EN
  logic [0:16*KEY_WORDS-1] key_q;
  logic [WW-1:0]           wcnt_q;
`endif

  // State register
  always_ff @(posedge mclk) begin
    if (puc_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = S_CHECK;
      S_CHECK: state_d = bus.spm_select_valid ? S_FETCH : S_RESP;
      S_FETCH: begin
        if (cnt_q == LAST_FIELD) begin
`ifdef SPM_QUERY_KEY_STREAM_EN
          // A SPM that vanished at any point of the fetch yields an error response, so no key is sent.
          state_d = (bus.spm_select_valid && !drop_q) ? S_KEY : S_RESP;
`else
          state_d = S_RESP;
`endif
        end
      end
      S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
`ifdef SPM_QUERY_KEY_STREAM_EN
      S_KEY:   if (bus.key_ready && wcnt_q == LAST_WORD) state_d = S_RESP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    bus.req_ready    = (state_q == S_IDLE);
    bus.resp_valid   = (state_q == S_RESP);
    bus.data_request = (state_q == S_FETCH) ? cnt_q : 3'd0;
`ifdef SPM_QUERY_KEY_STREAM_EN
    bus.key_valid    = (state_q == S_KEY);
    bus.key_word     = (state_q == S_KEY) ? key_q[{wcnt_q, 4'b0000} +: 16] : 16'h0000;
`endif
  end

  // Datapath: select latch, field capture, error tracking, key snapshot
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      for (int unsigned i = 1; i <= NB_FIELDS; i++) fields_q[i] <= '0;
`ifdef SPM_QUERY_KEY_STREAM_EN
      key_q  <= '0;
      wcnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            sel_q  <= bus.req_select;
            err_q  <= 1'b0;
            drop_q <= 1'b0;
          end
        end
        S_CHECK: begin
          for (int unsigned i = 1; i <= NB_FIELDS; i++) fields_q[i] <= '0;
          if (bus.spm_select_valid) cnt_q <= 3'd1;
          else                      err_q <= 1'b1;
        end
        S_FETCH: begin
          fields_q[cnt_q] <= bus.requested_data;
          if (!bus.spm_select_valid) drop_q <= 1'b1;
          if (cnt_q == LAST_FIELD) begin
            cnt_q <= '0;
            err_q <= drop_q | ~bus.spm_select_valid;
`ifdef SPM_QUERY_KEY_STREAM_EN
            key_q  <= bus.key_out;
            wcnt_q <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
`ifdef SPM_QUERY_KEY_STREAM_EN
        S_KEY: begin
          if (bus.key_ready) wcnt_q <= (wcnt_q == LAST_WORD) ? '0 : wcnt_q + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.spm_select     = sel_q;
  assign bus.resp_err       = err_q;
  assign bus.resp_pub_start = fields_q[1];
  assign bus.resp_pub_end   = fields_q[2];
  assign bus.resp_sec_start = fields_q[3];
  assign bus.resp_sec_end   = fields_q[4];
  assign bus.resp_id        = fields_q[5];

endmodule
